rf_arbiter_2p: RTL and testbench
================================

RF_ARBITER_2P -- requirements
Module: rf_arbiter_2p

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning register-file word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2, meaning register-file address width in bits.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports req0, req1  input  1 each  access request from requester 0 / 1.
REQ-006 The block SHALL have ports we0, we1  input  1 each  1 = write, 0 = read, qualified by the matching req.
REQ-007 The block SHALL have ports addr0, addr1  input  ADDR_WIDTH each  target address.
REQ-008 The block SHALL have ports wdata0, wdata1  input  DATA_WIDTH each  write data.
REQ-009 The block SHALL have ports ack0, ack1  output  1 each  single-cycle completion pulse.
REQ-010 The block SHALL have port rdata  output  DATA_WIDTH  read result, valid when the matching ack is high.
REQ-011 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 The block SHALL have ports rf_wr_en  output  1, rf_w_addr and rf_r_addr  output  ADDR_WIDTH, rf_w_data  output  DATA_WIDTH, driving the register file.
REQ-013 The block SHALL have port rf_r_data  input  DATA_WIDTH  register-file read data, valid one clock after rf_r_addr is presented.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE and RWAIT.
REQ-015 In IDLE with an eligible request, the block SHALL latch the winner index, we, addr and wdata, then move to ISSUE.
REQ-016 In ISSUE for a write, the block SHALL drive rf_wr_en=1 with the latched addr and data for exactly one cycle, then return to IDLE.
REQ-017 In ISSUE for a read, the block SHALL drive rf_r_addr with the latched address, then move to RWAIT.
REQ-018 In RWAIT, the block SHALL register rf_r_data into rdata and return to IDLE.
REQ-019 The winner's ack SHALL pulse for exactly one cycle: the cycle after ISSUE for writes and after RWAIT for reads.
REQ-020 Latency from IDLE sampling req SHALL be 2 cycles to ack for a write and 3 cycles to ack for a read.
REQ-021 rdata SHALL hold its last read value until the next read completes; write acks SHALL leave it unchanged.
REQ-022 A requester SHALL hold req, we, addr and wdata stable until its ack, and the block SHALL sample them only in IDLE.
REQ-023 In the cycle its ack is high, a requester's req SHALL be ignored (masked), so a held req is not re-granted.
REQ-024 Arbitration (default): when both requests are eligible, the block SHALL grant the requester not granted last (round-robin); a single eligible request SHALL always be granted.
REQ-025 The last-grant pointer SHALL update only when a grant is made.
REQ-026 rf_wr_en SHALL be 0 in every state except write-ISSUE.
REQ-027 rf_w_addr, rf_r_addr and rf_w_data SHALL come from the latched request, never directly from requester inputs.
REQ-028 Requests arriving while busy SHALL wait; none SHALL be dropped or merged.

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL set state=IDLE, ack0=ack1=0, busy=0, rf_wr_en=0, rdata=0, latched fields=0, and the last-grant pointer=1 (requester 0 wins first).
REQ-030 Reset during ISSUE or RWAIT SHALL abort the operation with no ack; a write aborted by reset before its ISSUE edge SHALL not be committed.

Configuration
REQ-031 With macro RF_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win simultaneous requests and the last-grant pointer SHALL be absent.
REQ-032 With RF_ARB_FIXED_PRIO_EN undefined, round-robin per REQ-024 SHALL apply.

Verification
REQ-033 After reset, req0 write addr=2 data=0xA5 -> rf_wr_en=1 one cycle with w_addr=2, w_data=0xA5; ack0 2 cycles after sampling.
REQ-034 Following REQ-033, req1 read addr=2 -> ack1 3 cycles after sampling with rdata=0xA5; busy high for 2 cycles.
REQ-035 Both reqs held continuously (reads, addr 0 and 1) -> grants alternate 0,1,0,1; no requester starved; with RF_ARB_FIXED_PRIO_EN, requester 0 wins each simultaneous arbitration.
REQ-036 req0 held high through its ack -> exactly one ack0 pulse; no duplicate grant in the ack cycle.
REQ-037 reset asserted in RWAIT of a read -> no ack, busy=0, rdata=0 next cycle; a subsequent read of addr 2 still returns 0xA5.

Source files
------------

// File: rtl/rf_arbiter_2p.sv
// Two-requester arbiter in front of a single-port-per-direction register file.
// Optional build macro RF_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
module rf_arbiter_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_w_addr,
    output logic [ADDR_WIDTH-1:0] rf_r_addr,
    output logic [DATA_WIDTH-1:0] rf_w_data,
    input  logic [DATA_WIDTH-1:0] rf_r_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } state_t;

    state_t                state_r;
    logic                  owner_r;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  ack0_r;
    logic                  ack1_r;
    logic                  busy_r;
    logic                  wr_en_r;
`ifndef RF_ARB_FIXED_PRIO_EN
    logic                  last_r;
`endif

    logic                  elig0_s;
    logic                  elig1_s;
    logic                  grant_valid_s;
    logic                  grant_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;

    // Eligibility (a requester is masked while its ack is high) and winner selection.
    always_comb begin
        elig0_s       = req0 & ~ack0_r;
        elig1_s       = req1 & ~ack1_r;
        grant_valid_s = elig0_s | elig1_s;
        if (elig0_s && elig1_s) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            grant_s = 1'b0;
`else
            grant_s = ~last_r;
`endif
        end else if (elig1_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
            rdata_r <= {DATA_WIDTH{1'b0}};
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            busy_r  <= 1'b0;
            wr_en_r <= 1'b0;
`ifndef RF_ARB_FIXED_PRIO_EN
            last_r  <= 1'b1;
`endif
        end else begin
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            wr_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        owner_r <= grant_s;
                        we_r    <= sel_we_s;
                        addr_r  <= sel_addr_s;
                        wdata_r <= sel_wdata_s;
                        wr_en_r <= sel_we_s;
                        busy_r  <= 1'b1;
                        state_r <= ISSUE;
`ifndef RF_ARB_FIXED_PRIO_EN
                        last_r  <= grant_s;
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (we_r) begin
                        ack0_r  <= ~owner_r;
                        ack1_r  <= owner_r;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= RWAIT;
                    end
                end
                RWAIT: begin
                    // rf_r_data reflects rf_r_addr presented during ISSUE.
                    rdata_r <= rf_r_data;
                    ack0_r  <= ~owner_r;
                    ack1_r  <= owner_r;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign rdata     = rdata_r;
    assign busy      = busy_r;
    assign rf_wr_en  = wr_en_r;
    assign rf_w_addr = addr_r;
    assign rf_r_addr = addr_r;
    assign rf_w_data = wdata_r;

endmodule

// File: tb/tb_rf_arbiter_2p.sv
// Self-checking bench for rf_arbiter_2p: directed scenarios then random traffic
// against a transaction-latency reference model and a behavioural register file.
module tb_rf_arbiter_2p;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, busy, rf_wr_en;
    logic [7:0] rdata, rf_w_data, rf_r_data;
    logic [1:0] rf_w_addr, rf_r_addr;

    int vectors = 0;
    int miscompares = 0;

    rf_arbiter_2p #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .rf_wr_en(rf_wr_en), .rf_w_addr(rf_w_addr), .rf_r_addr(rf_r_addr),
        .rf_w_data(rf_w_data), .rf_r_data(rf_r_data)
    );

    always #5 clk = ~clk;

    // Behavioural register file: one-cycle registered read.
    logic [7:0] rf_mem [4];
    initial for (int i = 0; i < 4; i++) rf_mem[i] = 8'h00;
    always @(posedge clk) begin
        if (rf_wr_en) rf_mem[rf_w_addr] <= rf_w_data;
        rf_r_data <= rf_mem[rf_r_addr];
    end

    // Reference model: an operation occupies the block for a fixed number of edges.
    int         m_cnt = 0;
    logic       m_owner = 1'b0, m_we = 1'b0, m_last = 1'b1;
    logic [1:0] m_addr = 2'd0;
    logic [7:0] m_wdata = 8'h00;
    logic       x_ack0 = 1'b0, x_ack1 = 1'b0, x_wr = 1'b0, x_busy = 1'b0;
    logic [7:0] x_rdata = 8'h00;
    logic [7:0] mem [4];

    task automatic model_step();
        logic e0, e1;
        logic g;
        if (reset) begin
            m_cnt = 0; m_owner = 1'b0; m_we = 1'b0; m_addr = 2'd0; m_wdata = 8'h00;
            m_last = 1'b1; x_ack0 = 1'b0; x_ack1 = 1'b0; x_wr = 1'b0; x_rdata = 8'h00;
        end else begin
            e0 = req0 && !x_ack0;
            e1 = req1 && !x_ack1;
            x_ack0 = 1'b0; x_ack1 = 1'b0; x_wr = 1'b0;
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    if (m_we) mem[m_addr] = m_wdata;
                    else x_rdata = mem[m_addr];
                    if (m_owner) x_ack1 = 1'b1;
                    else x_ack0 = 1'b1;
                end
            end else if (e0 || e1) begin
                if (e0 && e1) begin
`ifdef RF_ARB_FIXED_PRIO_EN
                    g = 1'b0;
`else
                    g = (m_last == 1'b1) ? 1'b0 : 1'b1;
`endif
                end else begin
                    g = e1;
                end
                m_owner = g;
                m_last  = g;
                m_we    = g ? we1 : we0;
                m_addr  = g ? addr1 : addr0;
                m_wdata = g ? wdata1 : wdata0;
                m_cnt   = m_we ? 1 : 2;
                x_wr    = m_we;
            end
        end
        x_busy = (m_cnt > 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: model advances on the edge, DUT is compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("ack0", 32'(ack0), 32'(x_ack0));
        chk("ack1", 32'(ack1), 32'(x_ack1));
        chk("busy", 32'(busy), 32'(x_busy));
        chk("rf_wr_en", 32'(rf_wr_en), 32'(x_wr));
        chk("rdata", 32'(rdata), 32'(x_rdata));
        if (x_wr) begin
            chk("rf_w_addr", 32'(rf_w_addr), 32'(m_addr));
            chk("rf_w_data", 32'(rf_w_data), 32'(m_wdata));
        end
        if (x_busy && !m_we) chk("rf_r_addr", 32'(rf_r_addr), 32'(m_addr));
    endtask

    initial begin
        int got [$];
        int acks;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 2'd0; addr1 = 2'd0; wdata0 = 8'h00; wdata1 = 8'h00;

        // Reset state
        step(); step();
        chk("rst_w_addr", 32'(rf_w_addr), 32'd0);
        chk("rst_w_data", 32'(rf_w_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        step();

        // Write 0xA5 to address 2 from requester 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 8'hA5;
        step();
        chk("wr_en_issue", 32'(rf_wr_en), 32'd1);
        chk("wr_addr_issue", 32'(rf_w_addr), 32'd2);
        chk("wr_data_issue", 32'(rf_w_data), 32'hA5);
        step();
        chk("wr_ack0_lat2", 32'(ack0), 32'd1);
        chk("wr_en_off", 32'(rf_wr_en), 32'd0);
        req0 = 1'b0;

        // Read address 2 from requester 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd2;
        step();
        chk("rd_busy_c1", 32'(busy), 32'd1);
        step();
        chk("rd_busy_c2", 32'(busy), 32'd1);
        step();
        chk("rd_ack1_lat3", 32'(ack1), 32'd1);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        chk("rd_busy_done", 32'(busy), 32'd0);
        req1 = 1'b0;
        step();

        // Both requesters hold reads: grants must alternate
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd1;
        for (int c = 0; c < 30 && got.size() < 4; c++) begin
            step();
            if (ack0) got.push_back(0);
            if (ack1) got.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < got.size() && k < 4; k++) chk("rr_order", 32'(got[k]), 32'(k % 2));
        step();

        // Requester 0 holds req through its ack: single pulse, no grant in ack cycle
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd3; wdata0 = 8'h3C;
        acks = 0;
        step(); if (ack0) acks++;
        step(); if (ack0) acks++;
        step(); if (ack0) acks++;
        chk("hold_no_regrant", 32'(busy), 32'd0);
        chk("hold_one_ack", 32'(acks), 32'd1);
        req0 = 1'b0;
        step();

        // Reset during RWAIT aborts the read
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd2;
        step(); step();
        reset = 1'b1;
        step();
        chk("abort_ack1", 32'(ack1), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        reset = 1'b0; req1 = 1'b0;
        step();
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd2;
        step(); step(); step();
        chk("reread_ack0", 32'(ack0), 32'd1);
        chk("reread_rdata", 32'(rdata), 32'hA5);
        req0 = 1'b0;
        step();

        // Random traffic: each requester holds its request until acknowledged
        for (int c = 0; c < 400; c++) begin
            if (!req0 || x_ack0) begin
                req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
                addr0 = 2'($urandom_range(0, 3)); wdata0 = 8'($urandom);
            end
            if (!req1 || x_ack1) begin
                req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
                addr1 = 2'($urandom_range(0, 3)); wdata1 = 8'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
